// File: rtl/esn_pkg.sv
// Shared types, default sizes and Q0.15 limits for the echo-state reservoir step controller.
package esn_pkg;

    localparam int unsigned WORD_LEN_DEF = 16;
    localparam int unsigned NEU_IN_DEF   = 8;
    localparam int unsigned NEU_OUT_DEF  = 4;

    localparam logic [WORD_LEN_DEF-1:0] Q15_MAX = 16'h7FFF;
    localparam logic [WORD_LEN_DEF-1:0] Q15_MIN = 16'h8000;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWaitW,
        StRun,
        StCapture,
        StCommit
    } esn_state_e;

    function automatic int unsigned n_groups(int unsigned neu_in, int unsigned neu_out);
        return neu_in / neu_out;
    endfunction

    function automatic int unsigned cnt_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned G   = n_groups(NEU_IN_DEF, NEU_OUT_DEF);
    localparam int unsigned G_W = cnt_width(G);

endpackage

// File: rtl/esn_step_ctrl_if.sv
// Weight ROM and PE bus between the step controller (master) and the PE/ROM pair (slave).
interface esn_step_ctrl_if #(
    parameter int unsigned WORD_LEN = 16,
    parameter int unsigned NEU_IN   = 8,
    parameter int unsigned NEU_OUT  = 4,
    parameter int unsigned WADDR_W  = 4
);
    logic                                w_rd_en;
    logic [WADDR_W-1:0]                  w_addr;
    logic [WORD_LEN*NEU_IN*NEU_OUT-1:0]  w_data;
    logic                                pe_ce;
    logic [WORD_LEN*NEU_IN-1:0]          pe_data;
    logic [WORD_LEN*NEU_IN*NEU_OUT-1:0]  pe_weight;
    logic [WORD_LEN*NEU_OUT-1:0]         pe_q;

    modport master (
        output w_rd_en, w_addr, pe_ce, pe_data, pe_weight,
        input  w_data, pe_q
    );

    modport slave (
        input  w_rd_en, w_addr, pe_ce, pe_data, pe_weight,
        output w_data, pe_q
    );
endinterface

// File: rtl/esn_leak_unit.sv
// One-word Q0.15 leaky integrator: y = sat(x + ((q - x) >>> LEAK_SHIFT)), purely combinational.
module esn_leak_unit
    import esn_pkg::*;
#(
    parameter int unsigned LEAK_SHIFT = 1
) (
    input  logic [WORD_LEN_DEF-1:0] x,
    input  logic [WORD_LEN_DEF-1:0] q,
    output logic [WORD_LEN_DEF-1:0] y
);
    localparam int unsigned W = WORD_LEN_DEF;
    localparam logic signed [W+1:0] SAT_HI = {2'b00, Q15_MAX};
    localparam logic signed [W+1:0] SAT_LO = {2'b11, Q15_MIN};

    logic signed [W:0]   diff;
    logic signed [W:0]   step;
    logic signed [W+1:0] sum;

    always_comb begin
        // One extra bit keeps q - x exact over the full Q0.15 range
        diff = $signed({q[W-1], q}) - $signed({x[W-1], x});
        step = diff >>> LEAK_SHIFT;
        sum  = $signed({{2{x[W-1]}}, x}) + $signed({step[W], step});
        if (sum > SAT_HI) begin
            y = Q15_MAX;
        end else if (sum < SAT_LO) begin
            y = Q15_MIN;
        end else begin
            y = sum[W-1:0];
        end
    end

endmodule

// File: rtl/esn_step_ctrl.sv
// Echo-state reservoir step controller: per group fetch a weight tile, run the PE, capture outputs.
// Optional macro LEAKY_INTEG_EN blends PE outputs into the old state through esn_leak_unit.
module esn_step_ctrl
    import esn_pkg::*;
#(
    parameter int unsigned WORD_LEN   = WORD_LEN_DEF,
    parameter int unsigned NEU_IN     = NEU_IN_DEF,
    parameter int unsigned NEU_OUT    = NEU_OUT_DEF,
    parameter int unsigned PE_LAT     = 2,
    parameter int unsigned WADDR_W    = 4,
    parameter int unsigned LEAK_SHIFT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       init_load,
    input  logic [WORD_LEN*NEU_IN-1:0] init_data,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                step_count,
    output logic [WORD_LEN*NEU_IN-1:0] x_out,
    esn_step_ctrl_if.master            bus
);
    localparam int unsigned NGRP      = n_groups(NEU_IN, NEU_OUT);
    localparam int unsigned GW        = cnt_width(NGRP);
    localparam int unsigned RW        = cnt_width(PE_LAT);
    localparam int unsigned VEC_BITS  = WORD_LEN * NEU_IN;
    localparam int unsigned GRP_BITS  = WORD_LEN * NEU_OUT;
    localparam int unsigned TILE_BITS = VEC_BITS * NEU_OUT;

    if (NEU_IN % NEU_OUT != 0 || (2 ** WADDR_W) < NGRP || PE_LAT == 0 ||
        LEAK_SHIFT >= WORD_LEN) begin : g_param_check
        $error("esn_step_ctrl: inconsistent parameters");
    end

    esn_state_e           state_q, state_d;
    logic [GW-1:0]        g_q, g_d;
    logic [RW-1:0]        run_q, run_d;
    logic [VEC_BITS-1:0]  x_q, x_d;
    logic [VEC_BITS-1:0]  nxt_q, nxt_d;
    logic [TILE_BITS-1:0] wt_q, wt_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [GRP_BITS-1:0]  upd_grp;

`ifdef LEAKY_INTEG_EN
    if (WORD_LEN != WORD_LEN_DEF) begin : g_leak_width_check
        $error("esn_step_ctrl: leaky integration is Q0.15 only");
    end

    logic [GRP_BITS-1:0] x_grp;
    assign x_grp = x_q[int'(g_q) * GRP_BITS +: GRP_BITS];

    for (genvar j = 0; j < NEU_OUT; j++) begin : g_leak
        esn_leak_unit #(
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_leak (
            .x (x_grp[j*WORD_LEN +: WORD_LEN]),
            .q (bus.pe_q[j*WORD_LEN +: WORD_LEN]),
            .y (upd_grp[j*WORD_LEN +: WORD_LEN])
        );
    end
`else
    assign upd_grp = bus.pe_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            g_q     <= '0;
            run_q   <= '0;
            x_q     <= '0;
            nxt_q   <= '0;
            wt_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            run_q   <= run_d;
            x_q     <= x_d;
            nxt_q   <= nxt_d;
            wt_q    <= wt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        run_d   = run_q;
        x_d     = x_q;
        nxt_d   = nxt_q;
        wt_d    = wt_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (init_load) begin
                    x_d = init_data;
                end else if (start) begin
                    g_d     = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StWaitW;
            end
            StWaitW: begin
                wt_d    = bus.w_data;
                run_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                if (run_q == RW'(PE_LAT - 1)) begin
                    state_d = StCapture;
                end else begin
                    run_d = run_q + 1'b1;
                end
            end
            StCapture: begin
                nxt_d[int'(g_q) * GRP_BITS +: GRP_BITS] = upd_grp;
                if (g_q == GW'(NGRP - 1)) begin
                    state_d = StCommit;
                end else begin
                    g_d     = g_q + 1'b1;
                    state_d = StFetch;
                end
            end
            StCommit: begin
                x_d     = nxt_q;
                cnt_d   = cnt_q + 16'd1;
                g_d     = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // PE DATA is the committed state, so every group reads the old vector
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StCommit);
    assign step_count    = cnt_q;
    assign x_out         = x_q;
    assign bus.w_rd_en   = (state_q == StFetch);
    assign bus.w_addr    = WADDR_W'(g_q);
    assign bus.pe_ce     = (state_q == StRun);
    assign bus.pe_data   = x_q;
    assign bus.pe_weight = wt_q;

endmodule

// File: tb/tb_esn_step_ctrl.sv
// Self-checking bench for esn_step_ctrl with a stub weight ROM and a 2-stage stub PE.
module tb_esn_step_ctrl;
    import esn_pkg::*;

    localparam int unsigned W   = 16;
    localparam int unsigned NI  = 8;
    localparam int unsigned NO  = 4;
    localparam int unsigned PL  = 2;
    localparam int unsigned AW  = 4;
    localparam int unsigned LS  = 1;
    localparam int          LAT = G * (PL + 3) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic            init_load = 1'b0;
    logic [W*NI-1:0] init_data = '0;
    logic            busy;
    logic            done;
    logic [15:0]     step_count;
    logic [W*NI-1:0] x_out;

    esn_step_ctrl_if #(.WORD_LEN(W), .NEU_IN(NI), .NEU_OUT(NO), .WADDR_W(AW)) bus ();

    esn_step_ctrl #(
        .WORD_LEN   (W),
        .NEU_IN     (NI),
        .NEU_OUT    (NO),
        .PE_LAT     (PL),
        .WADDR_W    (AW),
        .LEAK_SHIFT (LS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .init_load  (init_load),
        .init_data  (init_data),
        .busy       (busy),
        .done       (done),
        .step_count (step_count),
        .x_out      (x_out),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Stub PE: q_j = w[j][0] + sum_i (d_i & w[j][i]), modulo 2^16
    function automatic logic [W*NO-1:0] pe_func(logic [W*NI-1:0] d, logic [W*NI*NO-1:0] w);
        logic [W*NO-1:0] r;
        logic [W-1:0]    acc;
        for (int j = 0; j < NO; j++) begin
            acc = w[(j*NI)*W +: W];
            for (int i = 0; i < NI; i++) acc = acc + (d[i*W +: W] & w[(j*NI+i)*W +: W]);
            r[j*W +: W] = acc;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] f_upd(logic [W-1:0] q, logic [W-1:0] x);
`ifdef LEAKY_INTEG_EN
        int sq, sx, s;
        sq = int'($signed(q));
        sx = int'($signed(x));
        s  = sx + ((sq - sx) >>> LS);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s[W-1:0];
`else
        return q | (x & 16'h0000);
`endif
    endfunction

    logic [W*NI*NO-1:0] rom [G];
    logic [W*NO-1:0]    pe_s1;

    always @(posedge clk) if (bus.w_rd_en) bus.w_data <= rom[int'(bus.w_addr) % G];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_s1    <= '0;
            bus.pe_q <= '0;
        end else if (bus.pe_ce) begin
            pe_s1    <= pe_func(bus.pe_data, bus.pe_weight);
            bus.pe_q <= pe_s1;
        end
    end

    int          ce_cycles = 0;
    logic [AW-1:0] addr_log[$];
    always @(negedge clk) begin
        if (bus.pe_ce) ce_cycles++;
        if (bus.w_rd_en) addr_log.push_back(bus.w_addr);
    end

`ifdef LEAKY_INTEG_EN
    logic [W-1:0] lk_x, lk_q, lk_y;
    esn_leak_unit #(.LEAK_SHIFT(1)) u_leak (.x(lk_x), .q(lk_q), .y(lk_y));
`endif

    int              checks = 0;
    int              failures = 0;
    logic [W*NI-1:0] m_x;
    logic [15:0]     m_cnt;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W*NI-1:0] rand_vec();
        logic [W*NI-1:0] v;
        for (int i = 0; i < NI; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    function automatic logic [W*NI*NO-1:0] rand_tile();
        logic [W*NI*NO-1:0] v;
        for (int i = 0; i < NI*NO; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    task automatic model_step();
        logic [W*NI-1:0] nx;
        logic [W*NO-1:0] q;
        for (int g = 0; g < G; g++) begin
            q = pe_func(m_x, rom[g]);
            for (int j = 0; j < NO; j++)
                nx[(g*NO+j)*W +: W] = f_upd(q[j*W +: W], m_x[(g*NO+j)*W +: W]);
        end
        m_x   = nx;
        m_cnt = m_cnt + 16'd1;
    endtask

    // Called just after a negedge; returns the cycle index of done (-1 on timeout)
    task automatic do_step(output int lat);
        lat   = -1;
        start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat, ce0, a0, nd, t_done, t1, t2, t3;

        // Reset with random inputs
        #1;
        rst_n     = 1'b0;
        start     = 1'($urandom);
        init_load = 1'($urandom);
        init_data = rand_vec();
        repeat (3) @(negedge clk);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_pe_ce", 128'(bus.pe_ce), 128'(0));
        chk("rst_w_rd_en", 128'(bus.w_rd_en), 128'(0));
        chk("rst_x_out", 128'(x_out), 128'(0));
        chk("rst_step_count", 128'(step_count), 128'(0));
        chk("rst_pe_weight", 128'(bus.pe_weight == '0), 128'(1));
        start = 1'b0; init_load = 1'b0; rst_n = 1'b1;
        m_x = '0; m_cnt = '0;
        @(negedge clk);

        // Basic step with constant tiles
        for (int t = 0; t < G; t++) begin
            rom[t] = '0;
            for (int j = 0; j < NO; j++) rom[t][(j*NI)*W +: W] = W'((t + 1) * 16'h0100);
        end
        init_data = {NI{16'h1000}};
        init_load = 1'b1;
        @(negedge clk);
        init_load = 1'b0;
        m_x = init_data;
        chk("init_load_x", 128'(x_out), 128'(m_x));
        ce0 = ce_cycles; a0 = addr_log.size();
        do_step(lat);
        model_step();
        repeat (2) @(negedge clk);
        chk("basic_latency", 128'(lat), 128'(LAT));
        chk("basic_ce_cycles", 128'(ce_cycles - ce0), 128'(G * PL));
        chk("basic_fetches", 128'(addr_log.size() - a0), 128'(G));
        chk("basic_addr0", 128'(addr_log[a0]), 128'(0));
        chk("basic_addr1", 128'(addr_log[a0+1]), 128'(1));
        chk("basic_x_const", 128'(x_out), {{4{16'h0200}}, {4{16'h0100}}});
        chk("basic_x_model", 128'(x_out), 128'(m_x));
        chk("basic_pe_data", 128'(bus.pe_data), 128'(m_x));
        chk("basic_count", 128'(step_count), 128'(m_cnt));

        // Busy lockout: start/init_load pulsed mid-step must be ignored
        for (int t = 0; t < G; t++) rom[t] = rand_tile();
        start = 1'b1; nd = 0; t_done = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            start = 1'b0; init_load = 1'b0;
            if (n == 3 || n == 7) begin
                start = 1'b1; init_load = 1'b1; init_data = rand_vec();
            end
            if (done) begin
                nd++;
                if (t_done < 0) t_done = n;
            end
        end
        model_step();
        chk("lock_done_count", 128'(nd), 128'(1));
        chk("lock_latency", 128'(t_done), 128'(LAT));
        chk("lock_x", 128'(x_out), 128'(m_x));
        chk("lock_count", 128'(step_count), 128'(m_cnt));

        // Mid-step reset during RUN of group 1
        start = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("mid_in_run", 128'(bus.pe_ce), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_pe_ce", 128'(bus.pe_ce), 128'(0));
        chk("mid_rst_x", 128'(x_out), 128'(0));
        chk("mid_rst_count", 128'(step_count), 128'(0));
        chk("mid_rst_w_addr", 128'(bus.w_addr), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        m_x = '0; m_cnt = '0;
        @(negedge clk);
        a0 = addr_log.size();
        do_step(lat);
        model_step();
        @(negedge clk);
        chk("post_rst_addr0", 128'(addr_log[a0]), 128'(0));
        chk("post_rst_latency", 128'(lat), 128'(LAT));
        chk("post_rst_x", 128'(x_out), 128'(m_x));
        chk("post_rst_count", 128'(step_count), 128'(m_cnt));

        // Randomized steps, optionally reloading the state
        for (int k = 0; k < 5; k++) begin
            for (int t = 0; t < G; t++) rom[t] = rand_tile();
            if ($urandom_range(1, 0) == 1) begin
                init_data = rand_vec();
                init_load = 1'b1;
                start     = 1'b1;
                @(negedge clk);
                init_load = 1'b0; start = 1'b0;
                m_x = init_data;
                chk("rand_load_wins", 128'(busy), 128'(0));
            end
            do_step(lat);
            model_step();
            @(negedge clk);
            chk("rand_latency", 128'(lat), 128'(LAT));
            chk("rand_x", 128'(x_out), 128'(m_x));
            chk("rand_count", 128'(step_count), 128'(m_cnt));
        end

        // Back-to-back with start held high
        start = 1'b1; nd = 0; t1 = -1; t2 = -1; t3 = -1;
        for (int n = 1; n <= 60 && nd < 3; n++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (nd == 1) t1 = n;
                if (nd == 2) t2 = n;
                if (nd == 3) t3 = n;
            end
        end
        start = 1'b0;
        repeat (3) model_step();
        repeat (3) @(negedge clk);
        chk("b2b_first", 128'(t1), 128'(LAT));
        chk("b2b_period1", 128'(t2 - t1), 128'(LAT + 1));
        chk("b2b_period2", 128'(t3 - t2), 128'(LAT + 1));
        chk("b2b_x", 128'(x_out), 128'(m_x));
        chk("b2b_count", 128'(step_count), 128'(m_cnt));

        // step_count wrap
        force dut.cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.cnt_q;
        @(negedge clk);
        m_cnt = 16'hFFFF;
        chk("wrap_preload", 128'(step_count), 128'(m_cnt));
        do_step(lat);
        model_step();
        @(negedge clk);
        chk("wrap_count", 128'(step_count), 128'(0));
        chk("wrap_x", 128'(x_out), 128'(m_x));

`ifdef LEAKY_INTEG_EN
        lk_x = 16'h4000; lk_q = 16'h0000; #1;
        chk("leak_half", 128'(lk_y), 128'(16'h2000));
        lk_x = 16'h8000; lk_q = 16'h7FFF; #1;
        chk("leak_span", 128'(lk_y), 128'(16'hFFFF));
        lk_x = 16'h7FFF; lk_q = 16'h7FFF; #1;
        chk("leak_max", 128'(lk_y), 128'(16'h7FFF));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
